// File: rtl/branch_exec_ctrl.sv
// Multicycle execute/branch sequencer: decodes one instruction at a time, drives the ALU,
// then either writes back the ALU result or resolves BEQ/BNE into a PC update.
module branch_exec_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        alu_zero,
  input  logic [31:0] alu_result,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic [31:0] imm_ext,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic        reg_write,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [31:0] pc,
  output logic        done,
  output logic        illegal
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, WB, BRANCH} state_t;
  state_t state, state_nx;

  logic [5:0]  opcode_q, funct_q;
  logic [4:0]  rd_q;
  logic [15:0] imm_q;
  logic        is_bne, zero_q;
  logic        xfer;

  // shamt field carries no meaning for this instruction subset
  logic unused_shamt;
  assign unused_shamt = ^instr[10:6];

  assign xfer = instr_valid && instr_ready;

  logic        dec_legal, dec_branch, dec_bne, dec_src_imm;
  logic [2:0]  dec_op;
  logic [4:0]  dec_wb;

  always_comb begin
    dec_legal   = 1'b0;
    dec_branch  = 1'b0;
    dec_bne     = 1'b0;
    dec_src_imm = 1'b0;
    dec_op      = 3'b000;
    dec_wb      = rd_q;
    case (opcode_q)
      6'b000000: begin
        dec_legal = 1'b1;
        case (funct_q)
          6'b100000: dec_op = 3'b000;
          6'b100010: dec_op = 3'b001;
          6'b100100: dec_op = 3'b010;
          6'b100101: dec_op = 3'b011;
          6'b101010: dec_op = 3'b100;
          default:   dec_legal = 1'b0;
        endcase
      end
      6'b001000: begin
        dec_legal   = 1'b1;
        dec_src_imm = 1'b1;
        dec_wb      = rt_addr;
      end
      6'b000100, 6'b000101: begin
        dec_legal  = 1'b1;
        dec_branch = 1'b1;
        dec_bne    = opcode_q[0];
        dec_op     = 3'b001;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  logic branch_q;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (xfer) state_nx = DECODE;
      DECODE:  state_nx = dec_legal ? EXEC : IDLE;
      EXEC:    state_nx = branch_q ? BRANCH : WB;
      WB:      state_nx = IDLE;
      BRANCH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == IDLE);
    illegal     = (state == DECODE) && !dec_legal;
    done        = illegal || (state == WB) || (state == BRANCH);
    reg_write   = (state == WB) && (wb_addr != 5'd0);
  end

  logic taken;
  assign taken = is_bne ? !zero_q : zero_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_q    <= '0;
      funct_q     <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      rs_addr     <= '0;
      rt_addr     <= '0;
      alu_op      <= 3'b000;
      alu_src_imm <= 1'b0;
      imm_ext     <= '0;
      wb_addr     <= '0;
      branch_q    <= 1'b0;
      is_bne      <= 1'b0;
      wb_data     <= '0;
      zero_q      <= 1'b0;
      pc          <= PC_RESET;
    end else begin
      case (state)
        IDLE: if (xfer) begin
          opcode_q <= instr[31:26];
          rs_addr  <= instr[25:21];
          rt_addr  <= instr[20:16];
          rd_q     <= instr[15:11];
          imm_q    <= instr[15:0];
          funct_q  <= instr[5:0];
        end
        DECODE: begin
          if (dec_legal) begin
            alu_op      <= dec_op;
            alu_src_imm <= dec_src_imm;
            imm_ext     <= {{16{imm_q[15]}}, imm_q};
            wb_addr     <= dec_wb;
            branch_q    <= dec_branch;
            is_bne      <= dec_bne;
          end else begin
            pc <= pc + STEP;
          end
        end
        EXEC: begin
          wb_data <= alu_result;
          zero_q  <= alu_zero;
        end
        WB:     pc <= pc + STEP;
        // shift drops imm_ext[31:30]; wrap modulo 2^32 is intended
        BRANCH: pc <= pc + STEP + (taken ? {imm_ext[29:0], 2'b00} : 32'd0);
        default: ;
      endcase
    end
  end

endmodule
